// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences a shared 4-bit adder across operand nibbles, LSB first
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES,
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic [3:0]   adder_a,
   output logic [3:0]   adder_b,
   output logic         adder_cin,
   input  logic [3:0]   adder_s,
   input  logic         adder_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   state_t          state, state_nxt;
   logic [IDXW-1:0] idx;
   logic            carry;
   logic [W-1:0]    a_reg, b_reg;
   logic            cin_reg;
   logic            accept, last_nibble;

   assign accept      = (state == S_IDLE) && start;
   assign last_nibble = (state == S_RUN) && (idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      adder_a   = 4'd0;
      adder_b   = 4'd0;
      adder_cin = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy      = 1'b1;
            adder_a   = a_reg[4*idx +: 4];
            adder_b   = b_reg[4*idx +: 4];
            adder_cin = (idx == '0) ? cin_reg : carry;
            if (idx == LAST_IDX) state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         carry   <= 1'b0;
         a_reg   <= '0;
         b_reg   <= '0;
         cin_reg <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         cin_reg <= cin;
         idx     <= '0;
         carry   <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (state == S_RUN) begin
         sum[4*idx +: 4] <= adder_s;
         carry           <= adder_cout;
         if (last_nibble) begin
            // Sign of the result comes straight from the final nibble, not the sum register.
            cout <= adder_cout;
            ovf  <= (a_reg[W-1] == b_reg[W-1]) && (adder_s[3] != a_reg[W-1]);
            idx  <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;
   logic [3:0]   adder_a, adder_b, adder_s;
   logic         adder_cin, adder_cout;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

   nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
      .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
      .adder_s(adder_s), .adder_cout(adder_cout)
   );

   always @(negedge clk) if (done) done_cnt++;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-width unsigned add, signed overflow from operand/result signs.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                        output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0] full;
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      s  = full[W-1:0];
      co = full[W];
      ov = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
   endtask

   // Launches one operation, waits for done, checks latency and result; all_cin_one
   // additionally requires adder_cin=1 in every RUN cycle.
   task automatic run_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic oc, input logic [W-1:0] es, input logic ec,
                         input logic eo, input bit all_cin_one);
      int cyc;
      int cin_ones;
      a = oa; b = ob; cin = oc; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      cin_ones = 0;
      while (!done && cyc < 40) begin
         if (busy && adder_cin) cin_ones++;
         step();
         cyc++;
      end
      check({name, " latency"}, cyc, NIBBLES);
      check({name, " sum"}, sum, es);
      check({name, " cout"}, cout, ec);
      check({name, " ovf"}, ovf, eo);
      if (all_cin_one) check({name, " adder_cin ones"}, cin_ones, NIBBLES);
      step();
      check({name, " done width"}, done, 0);
      check({name, " sum held"}, sum, es);
   endtask

   initial begin
      logic [W-1:0] ra, rb, es;
      logic rc, ec, eo;
      int d0, cyc, prev, n_done, bad_ports;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

      #12;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout/ovf", {cout, ovf}, 0);
      check("reset adder ports", {adder_a, adder_b, adder_cin}, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, (i == 1));

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         model(ra, rb, rc, es, ec, eo);
         run_op($sformatf("rand%0d", i), ra, rb, rc, es, ec, eo, 1'b0);
      end

      // start pulsed mid-RUN must be ignored
      d0 = done_cnt;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a = 16'hABCD; b = 16'h9999; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin step(); cyc++; end
      check("ignored start sum", sum, 16'h3333);
      repeat (NIBBLES + 3) step();
      check("ignored start one done", done_cnt - d0, 1);
      check("ignored start idle", busy, 0);

      // reset mid-RUN aborts with no done
      d0 = done_cnt;
      a = 16'hF0F0; b = 16'h0F0F; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort sum/cout/ovf", {sum, cout, ovf}, 0);
      check("abort adder ports", {adder_a, adder_b, adder_cin}, 0);
      #2 rst_n = 1'b1;
      repeat (NIBBLES + 3) step();
      check("abort no done", done_cnt - d0, 0);
      run_op("after abort", 16'h0102, 16'h0304, 1'b1, 16'h0407, 1'b0, 1'b0, 1'b0);

      // held start: back-to-back operations
      a = 16'h000F; b = 16'h0001; cin = 1'b0; start = 1'b1;
      prev = -1; n_done = 0; bad_ports = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (done) begin
            check("held sum", sum, 16'h0010);
            if (prev >= 0) check("held period", c - prev, NIBBLES + 2);
            prev = c;
            n_done++;
         end
         if ((!busy || done) && ({adder_a, adder_b, adder_cin} != 0)) bad_ports++;
      end
      start = 1'b0;
      check("held done count", n_done >= 4, 1);
      check("held idle/done adder ports zero", bad_ports, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
